data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port, byte-addressed, word-wide data memory between two requesters: port 0 (CPU load/store stage) and port 1 (loader/debug DMA).
- Sits between the requesters and the data memory.
- Round-robin arbitration, registered issue and registered response.
- Out-of-range accesses are blocked and flagged.

Parameters:
- DEPTH_WORDS, 16000, number of 32-bit words in the data memory; word index = addr >> 2.
- AW, 32, requester address width in bytes.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request; held until rsp0_valid.
- req0_we  in  1  port 0 write (1) or read (0).
- req0_addr  in  AW  port 0 byte address.
- req0_wdata  in  32  port 0 write data.
- rsp0_valid  out  1  one-cycle pulse; port 0 access complete.
- rsp0_rdata  out  32  port 0 read data; valid with rsp0_valid.
- rsp0_err  out  1  port 0 address out of range; valid with rsp0_valid.
- req1_valid, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err: same as port 0, for port 1.
- mem_A  out  32  memory byte address.
- mem_WD  out  32  memory write data.
- mem_WE  out  1  memory write enable.
- mem_RD  in  32  memory read data (combinational from mem_A).

Behaviour:
- Clocking: single clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, prio=0, latched request cleared, mem_A=0, mem_WD=0, mem_WE=0, rspN_valid=0, rspN_rdata=0, rspN_err=0.
- States: IDLE -> ACCESS -> RESP -> IDLE. Each access takes 3 cycles.
- IDLE:
  - No valid request: stay in IDLE.
  - One valid request: latch that port's sel, we, addr and wdata, then go to ACCESS.
  - Both valid: the port equal to prio wins; the other waits.
- ACCESS:
  - mem_A = latched addr; mem_WD = latched wdata.
  - oor = (addr >> 2) >= DEPTH_WORDS.
  - mem_WE = latched we & ~oor & ~rst. The write commits at the edge leaving ACCESS.
  - On that edge: capture mem_RD into the response register (forced to 0 if oor or we); capture err = oor; set prio = ~sel.
- RESP:
  - rsp[sel]_valid=1 for exactly one cycle, with rdata and err. The other port's rsp signals are 0.
  - rdata and err hold their values until the next response.
  - Next state is IDLE. The requester drops or changes its request after seeing rsp_valid.
- Latency: request seen in IDLE at cycle T -> rsp_valid at T+2. Back-to-back same-port throughput is 1 access per 3 cycles.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1...
- Address bits [1:0] are ignored; accesses are always full-word.
- Outside ACCESS, mem_WE=0 and mem_A/mem_WD hold their last values.
- Request inputs are sampled only in IDLE. Changes during ACCESS or RESP have no effect.
- Reset mid-operation: rst in ACCESS blocks the write (mem_WE gated by ~rst). rst in RESP suppresses rsp_valid on the following cycle. In all cases the block returns to IDLE with prio=0.
- If req_valid drops in IDLE before it is latched, no access is made.

Optional Feature:
- Macro: DMA_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0[31:0], grant_cnt1[31:0], conflict_cnt[31:0], err_cnt[31:0]. All reset to 0, wrap modulo 2^32.
  - grant_cntN increments when port N is latched in IDLE.
  - conflict_cnt increments in any IDLE cycle where both valids are 1.
  - err_cnt increments on entering RESP with err=1.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package data_mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP}, 2-bit;
  - localparams NUM_PORTS=2 and WORD_SHIFT=2;
  - request struct {we, addr, wdata}.
- One sub-module, rr_arb2: combinational 2-way round-robin picker; inputs valid[1:0] and prio, outputs sel and any.
- Counters are kept inline.

Test Plan:
- Single write, then read: port 0 writes 0xDEADBEEF to addr 0x10.
  - mem_WE=1 only in ACCESS, with mem_A=0x10; rsp0_valid at T+2 with err=0.
  - Port 0 then reads 0x10 -> rsp0_rdata=0xDEADBEEF.
- Simultaneous requests: both ports request from reset (prio=0).
  - Port 0 is served first (rsp0 at T+2); port 1 is latched at T+3 and gets rsp1 at T+5.
  - Repeating shows strict alternation.
- Out of range: port 1 writes to addr 4*16000=0xFA00.
  - mem_WE stays 0 throughout; rsp1_err=1, rsp1_rdata=0; memory contents unchanged.
- Reset during ACCESS: rst asserted in the ACCESS cycle of a write of 0x12345678 to 0x20.
  - No write occurs (readback of 0x20 returns the prior value); next cycle state=IDLE, all rsp=0.
- Unaligned address: port 0 reads addr 0x13 after 0xCAFEF00D was written to 0x10 -> rdata=0xCAFEF00D.
- With DMA_ARB_STATS_EN: 4 contended requests plus 1 out-of-range request.
  - grant_cnt0 + grant_cnt1 = 5, err_cnt = 1, conflict_cnt matches the cycles where both valids were high in IDLE.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned WORD_SHIFT = 2;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on contention the port equal to prio_i wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic       sel_o,
    output logic       any_o
);

    always_comb begin
        any_o = |valid_i;
        sel_o = (&valid_i) ? prio_i : valid_i[1];
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between CPU (port 0) and DMA (port 1).
// Define DMA_ARB_STATS_EN to add grant/conflict/error counters as extra outputs.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 16000,
    parameter int unsigned AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [31:0]   req0_wdata,
    output logic          rsp0_valid,
    output logic [31:0]   rsp0_rdata,
    output logic          rsp0_err,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [31:0]   req1_wdata,
    output logic          rsp1_valid,
    output logic [31:0]   rsp1_rdata,
    output logic          rsp1_err,
    output logic [31:0]   mem_A,
    output logic [31:0]   mem_WD,
    output logic          mem_WE,
    input  logic [31:0]   mem_RD
`ifdef DMA_ARB_STATS_EN
    ,
    output logic [31:0]   grant_cnt0,
    output logic [31:0]   grant_cnt1,
    output logic [31:0]   conflict_cnt,
    output logic [31:0]   err_cnt
`endif
);

    arb_state_e                       state_q, state_d;
    logic                             prio_q, sel_q;
    logic                             arb_sel, arb_any, latch_en, oor;
    mem_req_t                         req_q, req0, req1;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q;
    logic [NUM_PORTS-1:0]             err_q;

    rr_arb2 u_arb (
        .valid_i ({req1_valid, req0_valid}),
        .prio_i  (prio_q),
        .sel_o   (arb_sel),
        .any_o   (arb_any)
    );

    always_comb begin
        req0 = '{we: req0_we, addr: ADDR_W'(req0_addr), wdata: req0_wdata};
        req1 = '{we: req1_we, addr: ADDR_W'(req1_addr), wdata: req1_wdata};
        oor  = (req_q.addr >> WORD_SHIFT) >= ADDR_W'(DEPTH_WORDS);
    end

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    latch_en = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory bus is driven straight from the latched request so it holds outside ACCESS.
    always_comb begin
        mem_A      = req_q.addr;
        mem_WD     = req_q.wdata;
        mem_WE     = (state_q == ACCESS) && req_q.we && !oor && !rst;
        rsp0_valid = (state_q == RESP) && !sel_q;
        rsp1_valid = (state_q == RESP) && sel_q;
        rsp0_rdata = rdata_q[0];
        rsp1_rdata = rdata_q[1];
        rsp0_err   = err_q[0];
        rsp1_err   = err_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                sel_q <= arb_sel;
                req_q <= arb_sel ? req1 : req0;
            end
            if (state_q == ACCESS) begin
                rdata_q[sel_q] <= (oor || req_q.we) ? '0 : mem_RD;
                err_q[sel_q]   <= oor;
                prio_q         <= ~sel_q;
            end
        end
    end

`ifdef DMA_ARB_STATS_EN
    logic [31:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
            err_cnt_q      <= '0;
        end else begin
            if (latch_en && !arb_sel) grant_cnt0_q <= grant_cnt0_q + 32'd1;
            if (latch_en && arb_sel)  grant_cnt1_q <= grant_cnt1_q + 32'd1;
            if (state_q == IDLE && req0_valid && req1_valid) conflict_cnt_q <= conflict_cnt_q + 32'd1;
            if (state_q == ACCESS && oor) err_cnt_q <= err_cnt_q + 32'd1;
        end
    end

    always_comb begin
        grant_cnt0   = grant_cnt0_q;
        grant_cnt1   = grant_cnt1_q;
        conflict_cnt = conflict_cnt_q;
        err_cnt      = err_cnt_q;
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: word-array memory model plus a reference image
// updated in grant order; compiles with or without DMA_ARB_STATS_EN.
module tb_data_mem_arbiter;

    localparam int unsigned DEPTH = 16000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;
`ifdef DMA_ARB_STATS_EN
    logic [31:0] grant_cnt0, grant_cnt1, conflict_cnt, err_cnt;
`endif

    logic [31:0] mem_arr [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DEPTH_WORDS(DEPTH), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
`ifdef DMA_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
        .conflict_cnt(conflict_cnt), .err_cnt(err_cnt)
`endif
    );

    // Out-of-range reads return garbage so the arbiter's zero-forcing is visible.
    assign mem_RD = (mem_A[31:2] < DEPTH) ? mem_arr[mem_A[31:2]] : 32'hBADC0FFE;

    always @(posedge clk) begin
        if (mem_WE && mem_A[31:2] < DEPTH) mem_arr[mem_A[31:2]] <= mem_WD;
    end

    function automatic logic is_oor(input logic [31:0] a);
        return a[31:2] >= DEPTH;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
    endfunction

    task automatic drive(input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic get_rsp(input int p, output logic v, output logic [31:0] rd, output logic er);
        v  = (p == 0) ? rsp0_valid : rsp1_valid;
        rd = (p == 0) ? rsp0_rdata : rsp1_rdata;
        er = (p == 0) ? rsp0_err   : rsp1_err;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One uncontended access: checks bus timing, latency, response data and error flag.
    task automatic single_access(input int p, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, input string name);
        logic        exp_oor, exp_we, got, v, er, got_err, got_other;
        logic [31:0] exp_rd, rd, got_rd;
        int          lat;
        exp_oor = is_oor(addr);
        exp_rd  = 32'd0;
        if (!we && !exp_oor) exp_rd = ref_mem[addr[31:2]];
        @(negedge clk);
        drive(p, 1'b1, we, addr, wd);
        got = 1'b0; lat = 0; got_rd = '0; got_err = 1'b0; got_other = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            exp_we = (c == 1) && we && !exp_oor;
            checks++;
            if (mem_WE !== exp_we) begin
                errors++;
                $display("FAIL %s_we: cycle %0d mem_WE=%b expected %b", name, c, mem_WE, exp_we);
            end
            if (c == 1) begin
                checks++;
                if (mem_A !== addr || mem_WD !== wd) begin
                    errors++;
                    $display("FAIL %s_bus: mem_A=%h mem_WD=%h expected %h %h", name, mem_A, mem_WD, addr, wd);
                end
            end
            get_rsp(p, v, rd, er);
            if (v === 1'b1) begin
                got = 1'b1; lat = c; got_rd = rd; got_err = er;
                got_other = (p == 0) ? rsp1_valid : rsp0_valid;
            end
        end
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL %s_lat: latency %0d expected 2 (0 = no response)", name, lat);
        end
        if (got) begin
            checks++;
            if (got_rd !== exp_rd || got_err !== exp_oor || got_other !== 1'b0) begin
                errors++;
                $display("FAIL %s_rsp: rdata=%h err=%b other_valid=%b expected %h %b 0",
                         name, got_rd, got_err, got_other, exp_rd, exp_oor);
            end
        end
        if (we && !exp_oor) ref_mem[addr[31:2]] = wd;
    endtask

    // Both ports request continuously; grants must alternate starting with first_port.
    task automatic test_contention(input int n, input int first_port, input string name);
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        logic        pw [2];
        logic        v, er, is_rsp, exp0, exp1;
        logic [31:0] rd, exp_rd;
        int          wp;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            pw[p] = 1'($urandom_range(0, 1)); pa[p] = rand_addr(); pd[p] = $urandom();
            drive(p, 1'b1, pw[p], pa[p], pd[p]);
        end
        for (int c = 1; c <= 3 * n; c++) begin
            @(negedge clk);
            is_rsp = (c % 3 == 2);
            wp     = (first_port + (c - 2) / 3) % 2;
            exp0   = is_rsp && (wp == 0);
            exp1   = is_rsp && (wp == 1);
            checks++;
            if (rsp0_valid !== exp0 || rsp1_valid !== exp1) begin
                errors++;
                $display("FAIL %s_order: cycle %0d rsp0/1_valid=%b%b expected %b%b",
                         name, c, rsp0_valid, rsp1_valid, exp0, exp1);
            end
            if (is_rsp) begin
                get_rsp(wp, v, rd, er);
                exp_rd = pw[wp] ? 32'd0 : ref_mem[pa[wp][31:2]];
                checks++;
                if (rd !== exp_rd || er !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_data: port %0d rdata=%h err=%b expected %h 0", name, wp, rd, er, exp_rd);
                end
                if (pw[wp]) ref_mem[pa[wp][31:2]] = pd[wp];
                pw[wp] = 1'($urandom_range(0, 1)); pa[wp] = rand_addr(); pd[wp] = $urandom();
                drive(wp, 1'b1, pw[wp], pa[wp], pd[wp]);
            end
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mem_WE} !== 5'b0 ||
            rsp0_rdata !== 32'd0 || rsp1_rdata !== 32'd0 || mem_A !== 32'd0 || mem_WD !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b%b err=%b%b we=%b rd0=%h rd1=%h A=%h WD=%h expected all 0",
                     rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mem_WE, rsp0_rdata, rsp1_rdata, mem_A, mem_WD);
        end
`ifdef DMA_ARB_STATS_EN
        checks++;
        if ((grant_cnt0 | grant_cnt1 | conflict_cnt | err_cnt) !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: %h %h %h %h expected 0", grant_cnt0, grant_cnt1, conflict_cnt, err_cnt);
        end
`endif
    endtask

    task automatic test_write_read();
        single_access(0, 1'b1, 32'h10, 32'hDEADBEEF, "wr0");
        single_access(0, 1'b0, 32'h10, 32'h0, "rd0");
        single_access(1, 1'b0, 32'h10, 32'h0, "rd1");
    endtask

    task automatic test_unaligned();
        single_access(0, 1'b1, 32'h10, 32'hCAFEF00D, "ua_wr");
        single_access(0, 1'b0, 32'h13, 32'h0, "ua_rd");
        single_access(1, 1'b1, 32'h16, 32'h0BADF00D, "ua_wr1");
        single_access(0, 1'b0, 32'h14, 32'h0, "ua_rd1");
    endtask

    task automatic test_oor();
        single_access(1, 1'b1, 32'hFA00, 32'h55AA55AA, "oor_wr");
        single_access(1, 1'b0, 32'hFA00, 32'h0, "oor_rd");
        single_access(0, 1'b0, 32'hFFFF_FFFC, 32'h0, "oor_top");
        single_access(1, 1'b1, 32'hF9FC, 32'h600DCAFE, "last_wr");
        single_access(0, 1'b0, 32'hF9FF, 32'h0, "last_rd");
    endtask

    task automatic test_reset_access();
        single_access(0, 1'b1, 32'h20, 32'h11111111, "rsta_pre");
        single_access(0, 1'b0, 32'h20, 32'h0, "rsta_rd");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_WE !== 1'b0 || mem_A !== 32'h20) begin
            errors++;
            $display("FAIL rsta_block: mem_WE=%b mem_A=%h expected 0 00000020", mem_WE, mem_A);
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_err, mem_WE} !== 4'b0 || rsp0_rdata !== 32'd0 || mem_A !== 32'd0) begin
            errors++;
            $display("FAIL rsta_state: v=%b%b err=%b we=%b rd0=%h A=%h expected all 0",
                     rsp0_valid, rsp1_valid, rsp0_err, mem_WE, rsp0_rdata, mem_A);
        end
        rst = 1'b0;
        single_access(0, 1'b0, 32'h20, 32'h0, "rsta_readback");
    endtask

    task automatic test_random(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'(DEPTH * 4) + 32'($urandom_range(0, 4095)) : rand_addr();
            single_access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom(), "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_mem_image();
        int diffs = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem_arr[i] !== ref_mem[i]) diffs++;
        checks++;
        if (diffs != 0) begin
            errors++;
            $display("FAIL mem_image: %0d differing words, expected 0", diffs);
        end
    endtask

`ifdef DMA_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        test_contention(4, 0, "stats_cont");
        single_access(1, 1'b1, 32'hFA00, 32'h1, "stats_oor");
        checks++;
        if (grant_cnt0 !== 32'd2 || grant_cnt1 !== 32'd3 || conflict_cnt !== 32'd4 || err_cnt !== 32'd1) begin
            errors++;
            $display("FAIL stats: g0=%0d g1=%0d conf=%0d err=%0d expected 2 3 4 1",
                     grant_cnt0, grant_cnt1, conflict_cnt, err_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_arr[i] = 32'(i) * 32'h9E3779B9;
            ref_mem[i] = 32'(i) * 32'h9E3779B9;
        end
        test_reset();
        test_write_read();
        test_unaligned();
        test_oor();
        do_reset();
        test_contention(6, 0, "cont_a");
        test_contention(5, 0, "cont_b");
        test_contention(4, 1, "cont_c");
        test_reset_access();
        test_random(40);
`ifdef DMA_ARB_STATS_EN
        test_stats();
`endif
        test_mem_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
